// File: rtl/mt_seed_loader.sv
// mt_seed_loader
//   Expands one 32-bit seed into the full N-word Mersenne Twister start state
//   with the init_genrand recurrence and streams the words, in index order,
//   into the twister's state-load port. One word per cycle when load_ready
//   stays high; load_ready=0 stalls the stream without losing or repeating a
//   word.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   start       begin seeding (sampled only while idle)
//   seed        seed word, captured on an accepted start
//   load_ready  downstream accepts the presented word this cycle
//   load_value  value/word_idx hold a valid state word
//   value       state word mt[word_idx]
//   word_idx    index of the word on value
//   busy        seeding in progress
//   done        one-cycle pulse after the last word transfers
module mt_seed_loader #(
  parameter int          W     = 32,
  parameter int          N     = 624,
  parameter logic [31:0] F     = 32'd1812433253,
  localparam int         IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     seed,
  input  logic             load_ready,
  output logic             load_value,
  output logic [W-1:0]     value,
  output logic [IDX_W-1:0] word_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     cur;
  logic [W-1:0]     cur_nxt;
  logic             xfer;
  logic             last;

  // mt[i] = F * (mt[i-1] ^ (mt[i-1] >> 30)) + i, all modulo 2^W.
  // idx is the index of the current word, so the added term is idx+1.
  function automatic logic [W-1:0] next_word(input logic [W-1:0]     c,
                                             input logic [IDX_W-1:0] idx);
    logic [W-1:0] mix;
    mix = c ^ (c >> 30);
    return (F[W-1:0] * mix) + W'(idx) + W'(1);
  endfunction

  assign xfer    = (state == SEND) && load_ready;
  assign last    = (word_idx == IDX_W'(N - 1));
  assign cur_nxt = next_word(cur, word_idx);
  assign value   = cur;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)        state_nxt = SEND;
      SEND:    if (xfer && last) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    load_value = 1'b0;
    busy       = 1'b0;
    if (state == SEND) begin
      load_value = 1'b1;
      busy       = 1'b1;
    end
  end

  // Word register and index. The presented word is cleared after the final
  // transfer so an idle loader always shows value=0, word_idx=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      word_idx <= '0;
      done     <= 1'b0;
    end else begin
      done <= xfer && last;
      if (state == IDLE) begin
        if (start) begin
          cur      <= seed;
          word_idx <= '0;
        end
      end else if (xfer) begin
        if (last) begin
          cur      <= '0;
          word_idx <= '0;
        end else begin
          cur      <= cur_nxt;
          word_idx <= word_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mt_seed_loader.sv
// tb_mt_seed_loader
//   Scoreboard bench for mt_seed_loader. Each seeding pushes its expected
//   624 (index, word) pairs, computed by a C-style init_genrand model, into a
//   queue; a monitor pops and compares on every transfer and checks that done
//   only ever follows the last word.
module tb_mt_seed_loader;

  localparam int N = 624;

  logic        tb_clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] seed;
  logic        load_ready;
  logic        load_value;
  logic [31:0] value;
  logic [9:0]  word_idx;
  logic        busy;
  logic        done;

  always #5 tb_clk = ~tb_clk;

  mt_seed_loader dut (
    .clk        (tb_clk),
    .rst        (rst),
    .start      (start),
    .seed       (seed),
    .load_ready (load_ready),
    .load_value (load_value),
    .value      (value),
    .word_idx   (word_idx),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic [9:0]  idx;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_w[N];
  int          checks   = 0;
  int          errors   = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  logic        prev_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, req, req);
    end
  endtask

  // Reference init_genrand.
  task automatic model(input logic [31:0] s);
    model_w[0] = s;
    for (int i = 1; i < N; i++)
      model_w[i] = 32'd1812433253 * (model_w[i-1] ^ (model_w[i-1] >> 30)) + 32'(i);
  endtask

  task automatic push_stream(input logic [31:0] s);
    exp_t e;
    model(s);
    for (int i = 0; i < N; i++) begin
      e.idx = 10'(i);
      e.val = model_w[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  // Monitor: a transfer is whatever will be taken at the coming edge.
  always @(negedge tb_clk) begin
    if (rst) begin
      prev_last = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("done_after_last", 32'(prev_last), 32'd1);
      end
      prev_last = 1'b0;
      if (load_value && load_ready) begin
        exp_t e;
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'(word_idx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_idx", 32'(word_idx), 32'(e.idx));
          chk("xfer_val", value, e.val);
        end
        prev_last = (word_idx == 10'(N - 1));
      end
    end
  end

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_idx(input logic [9:0] target, input int budget);
    int n = 0;
    while (word_idx != target && n < budget) begin
      tick();
      n++;
    end
    chk("reach_idx", 32'(word_idx), 32'(target));
  endtask

  initial begin
    int          x0, d0, cnt;
    logic [31:0] hold_v;

    // 1 Reset with random inputs
    rst        = 1'b1;
    start      = 1'($urandom);
    seed       = $urandom;
    load_ready = 1'($urandom);
    tick();
    start = 1'($urandom); seed = $urandom; load_ready = 1'($urandom);
    tick();
    chk("rst_load_value", 32'(load_value), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_value", value, 32'd0);
    chk("rst_word_idx", 32'(word_idx), 32'd0);
    rst = 1'b0; start = 1'b0; load_ready = 1'b1;
    tick();

    // 2 seed=0, load_ready held high
    x0 = xfer_cnt; d0 = done_cnt;
    push_stream(32'd0);
    start = 1'b1; seed = 32'd0;
    tick();
    start = 1'b0;
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_w0", value, 32'd0);
    tick();
    chk("t2_w1", value, 32'd1);
    tick();
    chk("t2_w2", value, 32'd1812433255);
    wait_done(700, "t2_done");
    tick();
    chk("t2_done_one_cycle", 32'(done), 32'd0);
    chk("t2_idle_value", value, 32'd0);
    chk("t2_xfers", 32'(xfer_cnt - x0), 32'd624);
    chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // 3 seed=5489, latency start->done
    push_stream(32'd5489);
    start = 1'b1; seed = 32'd5489;
    tick();
    start = 1'b0;
    cnt = 1;
    chk("t3_w0", value, 32'd5489);
    while (!done && cnt < 700) begin
      tick();
      cnt++;
      if (cnt == 2) chk("t3_w1", value, 32'h4D98EE96);
    end
    chk("t3_latency", 32'(cnt), 32'd625);
    tick();

    // 4 stall at word 100, then random load_ready
    push_stream(32'd5489);
    start = 1'b1; seed = 32'd5489;
    tick();
    start = 1'b0;
    wait_idx(10'd100, 200);
    load_ready = 1'b0;
    hold_v = value;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_stall_idx", 32'(word_idx), 32'd100);
      chk("t4_stall_val", value, hold_v);
      chk("t4_stall_vld", 32'(load_value), 32'd1);
    end
    begin
      int n = 0;
      while (!done && n < 4000) begin
        load_ready = 1'($urandom);
        tick();
        n++;
      end
    end
    chk("t4_done", 32'(done), 32'd1);
    load_ready = 1'b1;
    tick();

    // 5 start mid-stream ignored; start in done cycle accepted
    push_stream(32'd5489);
    start = 1'b1; seed = 32'd5489;
    tick();
    start = 1'b0;
    wait_idx(10'd50, 100);
    start = 1'b1; seed = 32'd7;
    tick();
    start = 1'b0;
    wait_done(700, "t5_done");
    push_stream(32'd7);
    start = 1'b1; seed = 32'd7;
    tick();
    start = 1'b0;
    chk("t5_restart_vld", 32'(load_value), 32'd1);
    chk("t5_restart_w0", value, 32'd7);
    chk("t5_restart_idx", 32'(word_idx), 32'd0);
    wait_done(700, "t5_done2");
    tick();

    // 6 reset mid-stream
    push_stream(32'd0);
    start = 1'b1; seed = 32'd0;
    tick();
    start = 1'b0;
    wait_idx(10'd300, 400);
    rst = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    tick();
    rst = 1'b0;
    chk("t6_vld", 32'(load_value), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_idx", 32'(word_idx), 32'd0);
    repeat (5) tick();
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    x0 = xfer_cnt;
    push_stream(32'd0);
    start = 1'b1; seed = 32'd0;
    tick();
    start = 1'b0;
    chk("t6_w0", value, 32'd0);
    wait_done(700, "t6_done");
    tick();
    chk("t6_xfers", 32'(xfer_cnt - x0), 32'd624);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
